adder_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that computes a wide add/subtract (BW_DATA*N_CHUNK bits) on one shared BW_DATA-bit adder (adder_param), one chunk per cycle, LSB chunk first.
- Carry is registered between chunks.
- Sits between a requester and a consumer, with valid/ready handshakes on both sides.
- Trades latency for area wherever a wide ALU operation is infrequent.

---
 rtl/adder_seq_ctrl_pkg.sv | 19 +
 rtl/adder_seq_ctrl_adder.sv | 17 +
 rtl/adder_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_adder_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the chunked wide add/sub sequencer.
// State encoding and index sizing helper.
package adder_seq_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ceil(log2(n)), never below 1 so a single-chunk build still has an index bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_adder.sv
// Shared chunk adder: BW_DATA-bit add with carry in and carry out.
// One instance is time-multiplexed across all chunks of an operation.
module adder_param #(
  parameter int BW_DATA = 8
) (
  input  logic [BW_DATA-1:0] i_a,
  input  logic [BW_DATA-1:0] i_b,
  input  logic               i_cin,
  output logic [BW_DATA-1:0] o_sum,
  output logic               o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a}
                         + {1'b0, i_b}
                         + {{BW_DATA{1'b0}}, i_cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide add/sub sequencer: one BW_DATA chunk per cycle, LSB first,
// carry registered between chunks, valid/ready on both sides.
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int BW_DATA = 8,
  parameter int N_CHUNK = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [BW_DATA*N_CHUNK-1:0] i_a,
  input  logic [BW_DATA*N_CHUNK-1:0] i_b,
  input  logic                       i_cin,
  input  logic                       i_sub,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [BW_DATA*N_CHUNK-1:0] o_sum,
  output logic                       o_cout,
  output logic                       o_busy
);

  localparam int W  = BW_DATA * N_CHUNK;
  localparam int IW = clog2_min1(N_CHUNK);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_CHUNK - 1);

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;

  logic [BW_DATA-1:0] ch_a, ch_b, ch_sum;
  logic               ch_cout;
  logic               accept, last;

  assign accept = (state_q == ST_IDLE) && i_valid;
  assign last   = (idx_q == IDX_LAST);

  assign ch_a = a_q[idx_q*BW_DATA +: BW_DATA];
  assign ch_b = b_q[idx_q*BW_DATA +: BW_DATA];

  adder_param #(
    .BW_DATA(BW_DATA)
  ) u_adder (
    .i_a   (ch_a),
    .i_b   (ch_b),
    .i_cin (carry_q),
    .o_sum (ch_sum),
    .o_cout(ch_cout)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_valid) state_d = ST_RUN;
      ST_RUN:  if (last)    state_d = ST_DONE;
      ST_DONE: if (i_ready) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    unique case (state_q)
      ST_IDLE: o_ready = 1'b1;
      ST_RUN:  o_busy  = 1'b1;
      ST_DONE: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
      end
      default: o_ready = 1'b0;
    endcase
  end

  // Subtract is A + ~B + 1: invert B at accept, seed carry with 1
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = i_a;
      b_d     = i_sub ? ~i_b : i_b;
      carry_d = i_sub | i_cin;
      idx_d   = '0;
    end else if (state_q == ST_RUN) begin
      sum_d[idx_q*BW_DATA +: BW_DATA] = ch_sum;
      carry_d = ch_cout;
      idx_d   = last ? '0 : idx_q + 1'b1;
      if (last) cout_d = ch_cout;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign o_sum  = sum_q;
  assign o_cout = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: a 4-chunk and a 1-chunk instance
// checked every cycle against a transaction-level model.
module tb_adder_seq_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int NC[2] = '{4, 1};

  logic        vin[2], rdy[2], cin[2], sub[2];
  logic [31:0] a[2], b[2];

  logic        ready_o[2], valid_o[2], busy_o[2], cout_o[2];
  logic [31:0] sum_o[2];

  logic        r0, v0, bz0, c0;
  logic        r1, v1, bz1, c1;
  logic [31:0] s0;
  logic [7:0]  s1;

  int n_vec = 0;
  int n_err = 0;

  adder_seq_ctrl #(.BW_DATA(8), .N_CHUNK(4)) u_dut4 (
    .i_clk(clk), .i_rstn(rstn),
    .i_valid(vin[0]), .o_ready(r0),
    .i_a(a[0]), .i_b(b[0]),
    .i_cin(cin[0]), .i_sub(sub[0]),
    .o_valid(v0), .i_ready(rdy[0]),
    .o_sum(s0), .o_cout(c0), .o_busy(bz0)
  );

  adder_seq_ctrl #(.BW_DATA(8), .N_CHUNK(1)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn),
    .i_valid(vin[1]), .o_ready(r1),
    .i_a(a[1][7:0]), .i_b(b[1][7:0]),
    .i_cin(cin[1]), .i_sub(sub[1]),
    .o_valid(v1), .i_ready(rdy[1]),
    .o_sum(s1), .o_cout(c1), .o_busy(bz1)
  );

  always_comb begin
    ready_o[0] = r0;  ready_o[1] = r1;
    valid_o[0] = v0;  valid_o[1] = v1;
    busy_o[0]  = bz0; busy_o[1]  = bz1;
    cout_o[0]  = c0;  cout_o[1]  = c1;
    sum_o[0]   = s0;  sum_o[1]   = {24'd0, s1};
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // {cout, sum} of a w-bit operation, straight from the arithmetic rules
  function automatic logic [32:0] ref_op(int w, logic [31:0] x,
                                         logic [31:0] y, bit c, bit s);
    logic [63:0] m, r, rs;
    m  = (64'd1 << w) - 64'd1;
    r  = ({32'd0, x} & m) + ({32'd0, (s ? ~y : y)} & m)
       + ((s | c) ? 64'd1 : 64'd0);
    rs = r & m;
    return {r[w], rs[31:0]};
  endfunction

  // Transaction model: accept when free, result visible N cycles later,
  // held until the consumer takes it.
  bit          m_busy[2]  = '{0, 0};
  bit          m_valid[2] = '{0, 0};
  int          m_cnt[2]   = '{0, 0};
  logic [31:0] m_sum[2];
  bit          m_cout[2];

  always @(posedge clk or negedge rstn) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstn) begin
        m_busy[d]  = 0;
        m_valid[d] = 0;
        m_cnt[d]   = 0;
      end else if (!m_busy[d]) begin
        if (vin[d]) begin
          m_busy[d] = 1;
          m_cnt[d]  = NC[d];
          {m_cout[d], m_sum[d]} = ref_op(8 * NC[d], a[d], b[d],
                                         cin[d], sub[d]);
        end
      end else if (m_cnt[d] > 0) begin
        m_cnt[d]--;
        if (m_cnt[d] == 0) m_valid[d] = 1;
      end else if (rdy[d]) begin
        m_valid[d] = 0;
        m_busy[d]  = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_ready", d), ready_o[d], !m_busy[d]);
      chk($sformatf("d%0d_busy", d), busy_o[d], m_busy[d]);
      chk($sformatf("d%0d_valid", d), valid_o[d], m_valid[d]);
      if (m_valid[d]) begin
        chk($sformatf("d%0d_sum", d), sum_o[d], m_sum[d]);
        chk($sformatf("d%0d_cout", d), cout_o[d], m_cout[d]);
      end
    end
  end

  task automatic start_op(int d, logic [31:0] ai, logic [31:0] bi,
                          bit ci, bit si);
    int n;
    a[d] = ai; b[d] = bi; cin[d] = ci; sub[d] = si;
    vin[d] = 1'b1;
    n = 0;
    while (!ready_o[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    vin[d] = 1'b0;
  endtask

  task automatic wait_valid(int d, int exp_lat);
    int lat;
    lat = 0;
    while (!valid_o[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("d%0d_latency", d), 64'(lat), 64'(exp_lat));
  endtask

  task automatic finish_op(int d, int bp, output logic [31:0] s,
                           output bit co);
    rdy[d] = 1'b0;
    repeat (bp) begin
      @(posedge clk); #1;
    end
    s  = sum_o[d];
    co = cout_o[d];
    rdy[d] = 1'b1;
    @(posedge clk); #1;
    rdy[d] = 1'b0;
  endtask

  logic [31:0] s;
  bit          co;

  initial begin
    for (int d = 0; d < 2; d++) begin
      vin[d] = 0; rdy[d] = 0; cin[d] = 0; sub[d] = 0;
      a[d] = '0; b[d] = '0;
    end
    #2 rstn = 1'b0;
    #1;
    chk("rst_ready", ready_o[0], 1);
    chk("rst_valid", valid_o[0], 0);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_sum", sum_o[0], 0);
    chk("rst_cout", cout_o[0], 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    start_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
    wait_valid(0, 4);
    finish_op(0, 0, s, co);
    chk("t1_sum", s, 32'h0000_0000);
    chk("t1_cout", co, 1);

    start_op(0, 32'd5, 32'd7, 1, 1);
    wait_valid(0, 4);
    finish_op(0, 1, s, co);
    chk("t2a_sum", s, 32'hFFFF_FFFE);
    chk("t2a_cout", co, 0);
    start_op(0, 32'd7, 32'd5, 1, 1);
    wait_valid(0, 4);
    finish_op(0, 0, s, co);
    chk("t2b_sum", s, 32'h0000_0002);
    chk("t2b_cout", co, 1);

    start_op(0, 32'h0F0F_0F0F, 32'h0101_0101, 1, 0);
    wait_valid(0, 4);
    a[0] = 32'd100; b[0] = 32'd200; cin[0] = 0; sub[0] = 0;
    vin[0] = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("t3_hold_ready", ready_o[0], 0);
    end
    chk("t3_sum", sum_o[0], 32'h1010_1011);
    chk("t3_cout", cout_o[0], 0);
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    rdy[0] = 1'b0;
    chk("t3_ready_rise", ready_o[0], 1);
    @(posedge clk); #1;
    vin[0] = 1'b0;
    chk("t3_reaccept", busy_o[0], 1);
    wait_valid(0, 4);
    finish_op(0, 0, s, co);
    chk("t3b_sum", s, 32'h0000_012C);
    chk("t3b_cout", co, 0);

    start_op(0, 32'h0102_0304, 32'h1020_3040, 0, 0);
    vin[0] = 1'b1;
    a[0] = 32'hFFFF_FFFF; b[0] = 32'hFFFF_FFFF; cin[0] = 1;
    repeat (2) begin
      @(posedge clk); #1;
      a[0] = ~a[0];
    end
    vin[0] = 1'b0;
    wait_valid(0, 2);
    finish_op(0, 2, s, co);
    chk("t4_sum", s, 32'h1122_3344);
    chk("t4_cout", co, 0);
    repeat (3) @(posedge clk);
    #1 chk("t4_single", busy_o[0], 0);

    start_op(0, 32'hAAAA_AAAA, 32'h5555_5555, 0, 0);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("t5_ready", ready_o[0], 1);
    chk("t5_valid", valid_o[0], 0);
    chk("t5_busy", busy_o[0], 0);
    chk("t5_sum", sum_o[0], 0);
    chk("t5_cout", cout_o[0], 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    start_op(0, 32'h1234_5678, 32'h1111_1111, 1, 0);
    wait_valid(0, 4);
    finish_op(0, 0, s, co);
    chk("t5b_sum", s, 32'h2345_678A);
    chk("t5b_cout", co, 0);

    start_op(1, 32'h80, 32'h80, 0, 0);
    wait_valid(1, 1);
    finish_op(1, 0, s, co);
    chk("t6_sum", s, 32'h00);
    chk("t6_cout", co, 1);

    for (int i = 0; i < 1500; i++) begin
      int d;
      d = (i < 1000) ? 1 : 0;
      start_op(d, $urandom, $urandom, 1'($urandom), 1'($urandom));
      wait_valid(d, NC[d]);
      finish_op(d, $urandom_range(0, 3), s, co);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
